// File: rtl/csr_pkg.sv
// csr_pkg: shared trap-sequencer state encoding, cause codes and machine-mode CSR constants
package csr_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MW, FLUSH} trap_state_e;
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MIE = 12'h304;
  localparam logic [11:0] MTVEC = 12'h305;
  localparam logic [11:0] MEPC = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;
  localparam logic [11:0] MIP = 12'h344;
  localparam logic [1:0] MTVEC_DIRECT = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
endpackage

// File: rtl/trap_vec_calc.sv
// trap_vec_calc: interrupt priority (external over timer) and mtvec target computation
module trap_vec_calc import csr_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            pend_ext,
  input  logic            pend_tmr,
  input  logic [XLEN-1:0] mtvec,
  output logic            take,
  output logic [3:0]      code,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] off;
  // reserved modes (1x) fall back to direct
  always_comb begin
    take = pend_ext | pend_tmr;
    code = pend_ext ? CAUSE_MEI : CAUSE_MTI;
    base = {mtvec[XLEN-1:2], 2'b00};
    off = {{(XLEN-6){1'b0}}, code, 2'b00};
    target = (mtvec[1:0] == MTVEC_VECTORED) ? base + off : base;
  end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: interrupt trap and mret sequencer committing precisely at the MW stage
module csr_trap_ctrl import csr_pkg::*; #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            valid_MW,
  input  logic            csr_wr_MW,
  input  logic            mret_MW,
  output logic            intr_expc,
  output logic            mret_o,
  output logic [XLEN-1:0] mcause_o,
  output logic            kill_wb,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_pipe
);
  localparam int CW = $clog2(FLUSH_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYC - 1);
  trap_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic pend_ext, pend_tmr, take, commit, do_mret;
  logic [3:0] code;
  logic [XLEN-1:0] target;
  assign pend_ext = ext_irq & mie_meie & mstatus_mie;
  assign pend_tmr = timer_irq & mie_mtie & mstatus_mie;
  trap_vec_calc #(.XLEN(XLEN)) u_vec (
    .pend_ext(pend_ext),
    .pend_tmr(pend_tmr),
    .mtvec(mtvec),
    .take(take),
    .code(code),
    .target(target)
  );
  // reset gates the commit so no pulse escapes in the cycle reset is applied
  always_comb begin
    do_mret = ~reset & (state == IDLE) & valid_MW & mret_MW;
    commit = ~reset & (state == WAIT_MW) & take & valid_MW & ~csr_wr_MW & ~mret_MW;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (commit | do_mret) ? CNT_LOAD : (state == FLUSH && cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
  // FLUSH is always visited so redirect pulses can never be back-to-back
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = do_mret ? FLUSH : take ? WAIT_MW : IDLE;
      WAIT_MW: state_n = commit ? FLUSH : take ? WAIT_MW : IDLE;
      FLUSH: state_n = (cnt <= CW'(1)) ? IDLE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    intr_expc = commit;
    kill_wb = commit;
    mret_o = do_mret;
    pc_redirect = commit | do_mret;
    mcause_o = commit ? {1'b1, {(XLEN-5){1'b0}}, code} : '0;
    redirect_pc = commit ? target : do_mret ? mepc : '0;
    flush_pipe = commit | do_mret | (~reset & (state == FLUSH) & (cnt != '0));
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: scoreboard bench for the trap sequencer
module tb_csr_trap_ctrl;
  logic clk = 0, reset = 1;
  logic ext_irq = 0, timer_irq = 0, mstatus_mie = 0, mie_meie = 0, mie_mtie = 0;
  logic [31:0] mtvec = 0, mepc = 0;
  logic valid_MW = 0, csr_wr_MW = 0, mret_MW = 0;
  logic intr_expc, mret_o, kill_wb, pc_redirect, flush_pipe;
  logic [31:0] mcause_o, redirect_pc;
  typedef struct packed {logic intr, mret, kill, redir, flush; logic [31:0] cause, pc;} exp_t;
  localparam logic [4:0] NONE = 5'b00000, TRAP = 5'b10111, MRET = 5'b01011, FL = 5'b00001;
  exp_t eq[$];
  string tq[$];
  int errors = 0, checks = 0;
  csr_trap_ctrl #(.XLEN(32), .FLUSH_CYC(2)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie),
    .mtvec(mtvec), .mepc(mepc), .valid_MW(valid_MW), .csr_wr_MW(csr_wr_MW),
    .mret_MW(mret_MW), .intr_expc(intr_expc), .mret_o(mret_o), .mcause_o(mcause_o),
    .kill_wb(kill_wb), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .flush_pipe(flush_pipe)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin : sb
    exp_t e;
    string t;
    if (eq.size() != 0) begin
      e = eq.pop_front();
      t = tq.pop_front();
      check({t, ".intr"}, 32'(intr_expc), 32'(e.intr));
      check({t, ".mret"}, 32'(mret_o), 32'(e.mret));
      check({t, ".kill"}, 32'(kill_wb), 32'(e.kill));
      check({t, ".redir"}, 32'(pc_redirect), 32'(e.redir));
      check({t, ".flush"}, 32'(flush_pipe), 32'(e.flush));
      if (e.intr) check({t, ".cause"}, mcause_o, e.cause);
      if (e.redir) check({t, ".pc"}, redirect_pc, e.pc);
    end
  end
  task automatic cyc(input string tag, input logic [4:0] f, input logic [31:0] c, input logic [31:0] p);
    eq.push_back({f, c, p});
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    mtvec = 32'h101; mepc = 32'h326; mstatus_mie = 1; mie_meie = 1; mie_mtie = 1;
    @(posedge clk); #1;
    cyc("rst", NONE, 0, 0);
    reset = 0; timer_irq = 1; valid_MW = 1;
    cyc("t1_idle", NONE, 0, 0);
    cyc("t1_trap", TRAP, 32'h8000_0007, 32'h11C);
    timer_irq = 0;
    cyc("t1_flush", FL, 0, 0);
    cyc("t1_done", NONE, 0, 0);
    mtvec = 32'h100; ext_irq = 1; timer_irq = 1;
    cyc("t2d_idle", NONE, 0, 0);
    cyc("t2d_trap", TRAP, 32'h8000_000B, 32'h100);
    ext_irq = 0; timer_irq = 0;
    cyc("t2d_flush", FL, 0, 0);
    mtvec = 32'h101; ext_irq = 1; timer_irq = 1;
    cyc("t2v_idle", NONE, 0, 0);
    cyc("t2v_trap", TRAP, 32'h8000_000B, 32'h12C);
    ext_irq = 0; timer_irq = 0;
    cyc("t2v_flush", FL, 0, 0);
    mtvec = 32'h102; ext_irq = 1;
    cyc("t2r_idle", NONE, 0, 0);
    cyc("t2r_trap", TRAP, 32'h8000_000B, 32'h100);
    ext_irq = 0; mtvec = 32'h101;
    cyc("t2r_flush", FL, 0, 0);
    timer_irq = 1; csr_wr_MW = 1;
    cyc("t3_idle", NONE, 0, 0);
    cyc("t3_csr", NONE, 0, 0);
    csr_wr_MW = 0; valid_MW = 0;
    cyc("t3_bubble", NONE, 0, 0);
    valid_MW = 1;
    cyc("t3_trap", TRAP, 32'h8000_0007, 32'h11C);
    timer_irq = 0;
    cyc("t3_flush", FL, 0, 0);
    cyc("t3_done", NONE, 0, 0);
    timer_irq = 1; mret_MW = 1;
    cyc("t4_mret", MRET, 0, 32'h326);
    mret_MW = 0;
    cyc("t4_flush", FL, 0, 0);
    cyc("t4_idle", NONE, 0, 0);
    cyc("t4_trap", TRAP, 32'h8000_0007, 32'h11C);
    timer_irq = 0;
    cyc("t4_flush2", FL, 0, 0);
    cyc("t4_done", NONE, 0, 0);
    timer_irq = 1; valid_MW = 0;
    cyc("t5_glitch", NONE, 0, 0);
    timer_irq = 0; valid_MW = 1;
    cyc("t5_drop", NONE, 0, 0);
    cyc("t5_idle", NONE, 0, 0);
    mstatus_mie = 0; timer_irq = 1; ext_irq = 1;
    for (int i = 0; i < 3; i++) cyc("t5_mie0", NONE, 0, 0);
    mstatus_mie = 1; ext_irq = 0; mie_mtie = 0;
    for (int i = 0; i < 2; i++) cyc("t5_mtie0", NONE, 0, 0);
    mie_mtie = 1; timer_irq = 0;
    cyc("t5_done", NONE, 0, 0);
    timer_irq = 1; valid_MW = 0;
    cyc("t6_idle", NONE, 0, 0);
    reset = 1; valid_MW = 1;
    cyc("t6_rst_wait", NONE, 0, 0);
    reset = 0;
    cyc("t6_after_rst", NONE, 0, 0);
    cyc("t6_trap", TRAP, 32'h8000_0007, 32'h11C);
    reset = 1;
    cyc("t6_rst_flush", NONE, 0, 0);
    reset = 0; timer_irq = 0; valid_MW = 0;
    cyc("t6_done", NONE, 0, 0);
    repeat (2) @(posedge clk);
    check("drain", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
